// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR / trap unit: addresses, reset
// values, WARL masks, cause codes and csr_op encodings.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam logic [31:0] MSTATUS_RST   = 32'h0000_1800;
  localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
  localparam logic [31:0] MIE_WMASK     = 32'h0000_0888;
  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;

  localparam logic [4:0] IRQ_M_SOFT  = 5'd3;
  localparam logic [4:0] IRQ_M_TIMER = 5'd7;
  localparam logic [4:0] IRQ_M_EXT   = 5'd11;

  typedef enum logic [4:0] {
    EXC_INSN_MISALIGN  = 5'd0,
    EXC_INSN_FAULT     = 5'd1,
    EXC_ILLEGAL_INSN   = 5'd2,
    EXC_BREAKPOINT     = 5'd3,
    EXC_LOAD_MISALIGN  = 5'd4,
    EXC_LOAD_FAULT     = 5'd5,
    EXC_STORE_MISALIGN = 5'd6,
    EXC_STORE_FAULT    = 5'd7,
    EXC_ECALL_U        = 5'd8,
    EXC_ECALL_S        = 5'd9,
    EXC_ECALL_M        = 5'd11
  } exc_code_e;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  // Only MIE/MPIE are stored; MPP is hardwired to machine mode.
  function automatic logic [31:0] mstatus_view(input logic mie, input logic mpie);
    logic [31:0] v;
    v = MSTATUS_RST & ~MSTATUS_WMASK;
    v[MSTATUS_MIE_BIT]  = mie;
    v[MSTATUS_MPIE_BIT] = mpie;
    return v;
  endfunction

  // Reserved mtvec modes 2 and 3 collapse to direct mode.
  function automatic logic [31:0] mtvec_warl(input logic [31:0] v);
    return {v[31:2], (v[1:0] == 2'b01) ? 2'b01 : 2'b00};
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independently writable 32-bit halves.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);

  logic [63:0] cnt;

  // A write to either half takes the place of this cycle's increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) cnt[31:0]  <= wdata;
      if (wr_hi) cnt[63:32] <= wdata;
    end else if (inc) begin
      cnt <= cnt + 64'd1;
    end
  end

  assign value = cnt;

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with trap entry, mret return, PC redirect and
// prioritised machine interrupt request.
module csr_trap_unit
  import csr_pkg::*;
#(
  parameter logic [31:0] MISA_VAL  = 32'h4000_0100,
  parameter logic [31:0] HART_ID   = 32'h0000_0000,
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
  parameter bit          CNT_EN    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_en,
  input  logic [2:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic        src_is_zero,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic        trap_req,
  input  logic        trap_is_irq,
  input  logic [4:0]  trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_tval,
  input  logic        mret,
  input  logic        instret,
  input  logic        irq_ext,
  input  logic        irq_sw,
  input  logic        irq_timer,
  output logic        irq_take,
  output logic [4:0]  irq_cause,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  logic        mstatus_mie, mstatus_mpie;
  logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [2:0]  mip_q;
  logic [31:0] mip_view;
  logic [63:0] mcycle_v, minstret_v;

  csr_op_e     op_kind;
  logic        csr_hit, wr_intent, illegal_raw, csr_we;
  logic [31:0] csr_old, csr_wval;
  logic        cyc_wr_lo, cyc_wr_hi, ins_wr_lo, ins_wr_hi;
  logic [31:0] mtvec_base, trap_target;
  logic [31:0] irq_pend;
  logic        unused_ok;

  assign op_kind  = csr_op_e'(csr_op[1:0]);
  assign mip_view = {20'b0, mip_q[2], 3'b0, mip_q[1], 3'b0, mip_q[0], 3'b0};
  assign unused_ok = csr_op[2];

  always_comb begin
    csr_hit = 1'b1;
    csr_old = '0;
    case (csr_addr)
      CSR_MSTATUS:               csr_old = mstatus_view(mstatus_mie, mstatus_mpie);
      CSR_MISA:                  csr_old = MISA_VAL;
      CSR_MIE:                   csr_old = mie_q;
      CSR_MTVEC:                 csr_old = mtvec_q;
      CSR_MSCRATCH:              csr_old = mscratch_q;
      CSR_MEPC:                  csr_old = mepc_q;
      CSR_MCAUSE:                csr_old = mcause_q;
      CSR_MTVAL:                 csr_old = mtval_q;
      CSR_MIP:                   csr_old = mip_view;
      CSR_MCYCLE, CSR_CYCLE:     csr_old = mcycle_v[31:0];
      CSR_MCYCLEH, CSR_CYCLEH:   csr_old = mcycle_v[63:32];
      CSR_MINSTRET, CSR_INSTRET: csr_old = minstret_v[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: csr_old = minstret_v[63:32];
      CSR_MHARTID:               csr_old = HART_ID;
      default:                   csr_hit = 1'b0;
    endcase
  end

  assign wr_intent   = (op_kind == CSR_OP_RW) ||
                       (((op_kind == CSR_OP_RS) || (op_kind == CSR_OP_RC)) && !src_is_zero);
  assign illegal_raw = csr_en && (!csr_hit || ((csr_addr[11:10] == 2'b11) && wr_intent));
  assign csr_illegal = !rst && illegal_raw;
  // Reads still see reset values while rst is high; only illegal accesses blank.
  assign csr_rdata   = illegal_raw ? '0 : csr_old;
  assign csr_we      = csr_en && !illegal_raw && wr_intent && !trap_req && !mret && !rst;

  always_comb begin
    csr_wval = csr_old;
    case (op_kind)
      CSR_OP_RW: csr_wval = csr_wdata;
      CSR_OP_RS: csr_wval = csr_old | csr_wdata;
      CSR_OP_RC: csr_wval = csr_old & ~csr_wdata;
      default:   csr_wval = csr_old;
    endcase
  end

  assign mtvec_base  = {mtvec_q[31:2], 2'b00};
  assign trap_target = ((mtvec_q[1:0] == 2'b01) && trap_is_irq)
                     ? mtvec_base + {25'b0, trap_cause, 2'b00}
                     : mtvec_base;

  assign redirect_valid = !rst && (trap_req || mret);
  assign redirect_pc    = rst      ? '0 :
                          trap_req ? trap_target :
                          mret     ? mepc_q : '0;

  assign irq_pend = mie_q & mip_view;
  assign irq_take = !rst && mstatus_mie && (|irq_pend);

  always_comb begin
    irq_cause = '0;
    if (!rst) begin
      if (irq_pend[IRQ_M_EXT])        irq_cause = IRQ_M_EXT;
      else if (irq_pend[IRQ_M_SOFT])  irq_cause = IRQ_M_SOFT;
      else if (irq_pend[IRQ_M_TIMER]) irq_cause = IRQ_M_TIMER;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_q        <= '0;
      mip_q        <= '0;
      mtvec_q      <= MTVEC_RST;
      mscratch_q   <= '0;
      mepc_q       <= '0;
      mcause_q     <= '0;
      mtval_q      <= '0;
    end else begin
      mip_q <= {irq_ext, irq_timer, irq_sw};
      if (trap_req) begin
        mepc_q       <= trap_pc & ~32'h3;
        mcause_q     <= {trap_is_irq, 26'b0, trap_cause};
        mtval_q      <= trap_tval;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else if (mret) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end else if (csr_we) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            mstatus_mie  <= csr_wval[MSTATUS_MIE_BIT];
            mstatus_mpie <= csr_wval[MSTATUS_MPIE_BIT];
          end
          CSR_MIE:      mie_q      <= csr_wval & MIE_WMASK;
          CSR_MTVEC:    mtvec_q    <= mtvec_warl(csr_wval);
          CSR_MSCRATCH: mscratch_q <= csr_wval;
          CSR_MEPC:     mepc_q     <= csr_wval & ~32'h3;
          CSR_MCAUSE:   mcause_q   <= csr_wval;
          CSR_MTVAL:    mtval_q    <= csr_wval;
          default: ;
        endcase
      end
    end
  end

  assign cyc_wr_lo = CNT_EN && csr_we && (csr_addr == CSR_MCYCLE);
  assign cyc_wr_hi = CNT_EN && csr_we && (csr_addr == CSR_MCYCLEH);
  assign ins_wr_lo = CNT_EN && csr_we && (csr_addr == CSR_MINSTRET);
  assign ins_wr_hi = CNT_EN && csr_we && (csr_addr == CSR_MINSTRETH);

  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (CNT_EN),
    .wr_lo (cyc_wr_lo),
    .wr_hi (cyc_wr_hi),
    .wdata (csr_wval),
    .value (mcycle_v)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .rst   (rst),
    .inc   (CNT_EN && instret),
    .wr_lo (ins_wr_lo),
    .wr_hi (ins_wr_hi),
    .wdata (csr_wval),
    .value (minstret_v)
  );

endmodule
